player_mover: RTL and testbench
===============================

PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameters: POS_X_W 14 (x position width); POS_Y_W 13 (y position width); ANGLE_W 8 (angle width); GRID_X_W 6; GRID_Y_W 5 (grid index widths); CELL_W 3 (grid cell width); TRIG_W 10 (signed trig width); TURN_STEP 2 (angle units per turn); SPEED_SHIFT 4 (move scale); FRAME_TICKS 2000000 (minimum cycles between applied updates).
REQ-002 Ports, one per line: clock in 1 system clock; reset in 1 synchronous active-high reset.
REQ-003 start in 1 update request; done out 1 update-complete pulse.
REQ-004 turn_right, turn_left, move_forward, move_backward in 1 each, key levels.
REQ-005 cur_pos_x in POS_X_W; cur_pos_y in POS_Y_W; cur_angle in ANGLE_W, current player state.
REQ-006 next_pos_x out POS_X_W; next_pos_y out POS_Y_W; next_angle out ANGLE_W, updated player state.
REQ-007 trig_angle out ANGLE_W; trig_cos, trig_sin in TRIG_W signed; external LUT with 1-cycle read latency.
REQ-008 grid_x out GRID_X_W; grid_y out GRID_Y_W; grid_out in CELL_W; external map with 1-cycle read latency.

Function
REQ-009 FSM states: IDLE, TRIG_REQ, TRIG_CAP, PROBE_X, CHECK_X, PROBE_Y, CHECK_Y/DONE; transitions unconditional except IDLE->TRIG_REQ on start.
REQ-010 In IDLE, start=1 latches keys and cur_* in the same cycle; start outside IDLE is ignored.
REQ-011 done is a one-cycle pulse exactly 6 cycles after start is accepted; next_* update in the done cycle and hold until the next done.
REQ-012 Throttle: a free-running counter counts cycles since the last applied update, saturating at FRAME_TICKS; if it is below FRAME_TICKS when start is accepted, next_* = latched cur_* (pass-through), still with 6-cycle done; applying an update clears the counter.
REQ-013 Turn: right only adds TURN_STEP, left only subtracts TURN_STEP, modulo 2^ANGLE_W; both or neither gives no change.
REQ-014 Movement uses the post-turn angle: trig_angle is driven in TRIG_REQ, and cos/sin are captured in TRIG_CAP.
REQ-015 dx = trig_cos >>> SPEED_SHIFT and dy = trig_sin >>> SPEED_SHIFT, arithmetic shift, sign-extended; forward only adds, backward only subtracts; both or neither gives no movement.
REQ-016 Candidate x = cur_x+dx, computed one bit wider; overflow outside [0, 2^POS_X_W-1] means blocked; same rule for y.
REQ-017 Cell index = top GRID_*_W bits of the position; a cell is a wall when grid_out != 0.
REQ-018 PROBE_X drives the cell of (cand_x, cur_y); CHECK_X accepts cand_x if it is free and unblocked, else keeps cur_x.
REQ-019 PROBE_Y drives the cell of (accepted_x, cand_y); CHECK_Y accepts cand_y likewise; the axes resolve independently (wall sliding).
REQ-020 When idle, grid_x/grid_y/trig_angle hold their last values.

Reset
REQ-021 On reset the FSM returns to IDLE and done=0; next_pos_x, next_pos_y, next_angle, grid_x, grid_y, trig_angle are set to 0.
REQ-022 The throttle counter resets to FRAME_TICKS, so the first request is applied.
REQ-023 Reset mid-operation aborts the update; no done is issued and next_* stay 0.

Configuration
REQ-024 Macro PLAYER_MOVER_STRAFE_EN: when defined, adds ports strafe_left and strafe_right (in, 1 bit); right only adds (-dy, +dx) and left only adds (+dy, -dx), summed with the forward/back deltas before the collision checks; both pressed cancel.
REQ-025 When the macro is undefined, these ports and this logic are absent, and behaviour is exactly REQ-009..023.

Verification
REQ-026 Defaults with FRAME_TICKS=10, empty grid, cur=(0x0880,0x0880), angle 0, cos=511, sin=0, forward, start -> done 6 cycles later, next=(0x089F,0x0880,0).
REQ-027 Cell (9,8)=1, cur_x=0x08F0, cur_y=0x0880, cos=511, sin=0, forward -> next_pos_x=0x08F0 (blocked), y unchanged.
REQ-028 Slide: cell (9,8)=1, cur=(0x08F0,0x0880), cos=361, sin=361, forward -> x stays 0x08F0, y=0x0896.
REQ-029 turn_left at angle 0x01 -> 0xFF; turn_left+turn_right -> angle unchanged; forward+backward -> position unchanged.
REQ-030 Accepted start at t0 and second start 8 cycles later (FRAME_TICKS=10) -> second done carries pass-through cur_*; third start at t0+20 is applied.
REQ-031 Reset asserted 3 cycles after start -> no done; next_*=0; next start completes normally.

Source files
------------

// File: rtl/player_mover.sv
// rtl/player_mover.sv - player turn/move update with grid collision checks and frame throttle
//
// Purpose: on an accepted start, applies turn keys to the angle, reads cos/sin of
// the new angle from an external LUT, moves along it (forward/backward), and checks
// each axis against an external wall map so the player can slide along walls.
// Results appear on next_* together with a one-cycle done, 6 cycles after start.
// Updates closer together than FRAME_TICKS cycles pass cur_* through unchanged.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   start / done            update request (accepted in IDLE) / completion pulse
//   turn_*, move_*          key levels, latched with start
//   cur_pos_x/y, cur_angle  current player state, latched with start
//   next_pos_x/y, next_angle updated player state, valid from done
//   trig_angle -> trig_cos/trig_sin   trig LUT, 1-cycle read latency
//   grid_x/grid_y -> grid_out         wall map, 1-cycle read latency
//
// Build option: define PLAYER_MOVER_STRAFE_EN to add strafe_left/strafe_right.

module player_mover #(
  parameter int POS_X_W     = 14,
  parameter int POS_Y_W     = 13,
  parameter int ANGLE_W     = 8,
  parameter int GRID_X_W    = 6,
  parameter int GRID_Y_W    = 5,
  parameter int CELL_W      = 3,
  parameter int TRIG_W      = 10,
  parameter int TURN_STEP   = 2,
  parameter int SPEED_SHIFT = 4,
  parameter int FRAME_TICKS = 2000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      done,
  input  logic                      turn_right,
  input  logic                      turn_left,
  input  logic                      move_forward,
  input  logic                      move_backward,
`ifdef PLAYER_MOVER_STRAFE_EN
  input  logic                      strafe_left,
  input  logic                      strafe_right,
`endif
  input  logic [POS_X_W-1:0]        cur_pos_x,
  input  logic [POS_Y_W-1:0]        cur_pos_y,
  input  logic [ANGLE_W-1:0]        cur_angle,
  output logic [POS_X_W-1:0]        next_pos_x,
  output logic [POS_Y_W-1:0]        next_pos_y,
  output logic [ANGLE_W-1:0]        next_angle,
  output logic [ANGLE_W-1:0]        trig_angle,
  input  logic signed [TRIG_W-1:0]  trig_cos,
  input  logic signed [TRIG_W-1:0]  trig_sin,
  output logic [GRID_X_W-1:0]       grid_x,
  output logic [GRID_Y_W-1:0]       grid_y,
  input  logic [CELL_W-1:0]         grid_out
);

  localparam int CNT_W = $clog2(FRAME_TICKS + 1);
  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_TICKS);
  // Delta width leaves headroom for forward + strafe sums.
  localparam int DW = TRIG_W + 2;
  // Candidate positions carry two extra bits: one for overflow, one for sign.
  localparam int XW = POS_X_W + 2;
  localparam int YW = POS_Y_W + 2;

  typedef enum logic [2:0] {
    IDLE, TRIG_REQ, TRIG_CAP, PROBE_X, CHECK_X, PROBE_Y, CHECK_Y
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   frame_cnt;
  logic               accept, apply;
  logic [ANGLE_W-1:0] turned_angle, angle_q;
  logic [POS_X_W-1:0] cur_x_q, cand_x_q, acc_x_q, acc_x;
  logic [POS_Y_W-1:0] cur_y_q, cand_y_q, acc_y;
  logic               fwd_q, bwd_q, blk_x_q, blk_y_q;
  logic               sl_q, sr_q;
  logic signed [TRIG_W-1:0] dx, dy;
  logic signed [DW-1:0]     dx_e, dy_e, mv_x, mv_y, side_x, side_y, del_x, del_y;
  logic [XW-1:0]      cand_x;
  logic [YW-1:0]      cand_y;

  assign accept = (state == IDLE) && start;
  assign apply  = (frame_cnt == FRAME_MAX);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = TRIG_REQ;
      TRIG_REQ: state_nxt = TRIG_CAP;
      TRIG_CAP: state_nxt = PROBE_X;
      PROBE_X:  state_nxt = CHECK_X;
      CHECK_X:  state_nxt = PROBE_Y;
      PROBE_Y:  state_nxt = CHECK_Y;
      CHECK_Y:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A throttled request takes the turn with no keys, so angle stays as-is.
  always_comb begin
    turned_angle = cur_angle;
    if (apply && turn_right && !turn_left)
      turned_angle = cur_angle + ANGLE_W'(TURN_STEP);
    else if (apply && turn_left && !turn_right)
      turned_angle = cur_angle - ANGLE_W'(TURN_STEP);
  end

  assign dx   = trig_cos >>> SPEED_SHIFT;
  assign dy   = trig_sin >>> SPEED_SHIFT;
  assign dx_e = DW'(dx);
  assign dy_e = DW'(dy);

  always_comb begin
    mv_x   = '0;
    mv_y   = '0;
    side_x = '0;
    side_y = '0;
    if (fwd_q && !bwd_q) begin
      mv_x = dx_e;
      mv_y = dy_e;
    end else if (bwd_q && !fwd_q) begin
      mv_x = -dx_e;
      mv_y = -dy_e;
    end
    if (sr_q && !sl_q) begin
      side_x = -dy_e;
      side_y = dx_e;
    end else if (sl_q && !sr_q) begin
      side_x = dy_e;
      side_y = -dx_e;
    end
    del_x = mv_x + side_x;
    del_y = mv_y + side_y;
  end

  // Any set bit above the position width means the candidate left the map.
  assign cand_x = {2'b00, cur_x_q} + XW'(del_x);
  assign cand_y = {2'b00, cur_y_q} + YW'(del_y);

  assign acc_x = (!blk_x_q && grid_out == '0) ? cand_x_q : cur_x_q;
  assign acc_y = (!blk_y_q && grid_out == '0) ? cand_y_q : cur_y_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      done       <= 1'b0;
      next_pos_x <= '0;
      next_pos_y <= '0;
      next_angle <= '0;
      trig_angle <= '0;
      grid_x     <= '0;
      grid_y     <= '0;
      frame_cnt  <= FRAME_MAX;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      acc_x_q    <= '0;
      angle_q    <= '0;
      fwd_q      <= 1'b0;
      bwd_q      <= 1'b0;
      sl_q       <= 1'b0;
      sr_q       <= 1'b0;
      blk_x_q    <= 1'b0;
      blk_y_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && apply)          frame_cnt <= '0;
      else if (frame_cnt != FRAME_MAX) frame_cnt <= frame_cnt + 1'b1;

      case (state)
        IDLE: if (start) begin
          cur_x_q    <= cur_pos_x;
          cur_y_q    <= cur_pos_y;
          angle_q    <= turned_angle;
          trig_angle <= turned_angle;
          // Masking the keys turns a throttled request into a pass-through.
          fwd_q      <= move_forward  & apply;
          bwd_q      <= move_backward & apply;
`ifdef PLAYER_MOVER_STRAFE_EN
          sl_q       <= strafe_left   & apply;
          sr_q       <= strafe_right  & apply;
`else
          sl_q       <= 1'b0;
          sr_q       <= 1'b0;
`endif
        end
        TRIG_CAP: begin
          cand_x_q <= cand_x[POS_X_W-1:0];
          cand_y_q <= cand_y[POS_Y_W-1:0];
          blk_x_q  <= |cand_x[XW-1:POS_X_W];
          blk_y_q  <= |cand_y[YW-1:POS_Y_W];
          grid_x   <= cand_x[POS_X_W-1 -: GRID_X_W];
          grid_y   <= cur_y_q[POS_Y_W-1 -: GRID_Y_W];
        end
        CHECK_X: begin
          acc_x_q <= acc_x;
          grid_x  <= acc_x[POS_X_W-1 -: GRID_X_W];
          grid_y  <= cand_y_q[POS_Y_W-1 -: GRID_Y_W];
        end
        CHECK_Y: begin
          next_pos_x <= acc_x_q;
          next_pos_y <= acc_y;
          next_angle <= angle_q;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// tb/tb_player_mover.sv - directed self-checking bench for player_mover
module tb_player_mover;

  logic clock = 1'b0;
  logic reset, start, done;
  logic turn_right, turn_left, move_forward, move_backward;
  logic strafe_left, strafe_right;
  logic [13:0] cur_pos_x, next_pos_x;
  logic [12:0] cur_pos_y, next_pos_y;
  logic [7:0]  cur_angle, next_angle, trig_angle;
  logic signed [9:0] trig_cos, trig_sin, lut_cos, lut_sin;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic [2:0]  grid_out;
  logic        wall_en;
  logic [5:0]  wall_x;
  logic [4:0]  wall_y;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  player_mover #(.FRAME_TICKS(10)) dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .turn_right(turn_right), .turn_left(turn_left),
    .move_forward(move_forward), .move_backward(move_backward),
`ifdef PLAYER_MOVER_STRAFE_EN
    .strafe_left(strafe_left), .strafe_right(strafe_right),
`endif
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
    .next_pos_x(next_pos_x), .next_pos_y(next_pos_y), .next_angle(next_angle),
    .trig_angle(trig_angle), .trig_cos(trig_cos), .trig_sin(trig_sin),
    .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out)
  );

  // External LUT and map, each with one cycle of read latency.
  always @(posedge clock) begin
    trig_cos <= lut_cos;
    trig_sin <= lut_sin;
    grid_out <= (wall_en && grid_x == wall_x && grid_y == wall_y) ? 3'd1 : 3'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issues one start and checks done latency, pulse width and the result.
  task automatic run_update(input string tag,
                            input logic [13:0] x, input logic [12:0] y, input logic [7:0] a,
                            input logic tr, input logic tl, input logic mf, input logic mb,
                            input logic signed [9:0] c, input logic signed [9:0] s,
                            input logic [13:0] ex, input logic [12:0] ey, input logic [7:0] ea);
    int lat;
    lat = -1;
    cur_pos_x = x; cur_pos_y = y; cur_angle = a;
    turn_right = tr; turn_left = tl; move_forward = mf; move_backward = mb;
    lut_cos = c; lut_sin = s;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      @(negedge clock);
      if (done) lat = i;
    end
    chk({tag, ".latency"}, lat, 6);
    chk({tag, ".next_x"}, 32'(next_pos_x), 32'(ex));
    chk({tag, ".next_y"}, 32'(next_pos_y), 32'(ey));
    chk({tag, ".next_angle"}, 32'(next_angle), 32'(ea));
    turn_right = 0; turn_left = 0; move_forward = 0; move_backward = 0;
    @(negedge clock);
    chk({tag, ".done_width"}, 32'(done), 0);
  endtask

  initial begin
    int done_cnt;
    reset = 1; start = 0;
    turn_right = 0; turn_left = 0; move_forward = 0; move_backward = 0;
    strafe_left = 0; strafe_right = 0;
    cur_pos_x = 0; cur_pos_y = 0; cur_angle = 0;
    lut_cos = 0; lut_sin = 0; wall_en = 0; wall_x = 6'd9; wall_y = 5'd8;
    idle(3);
    reset = 0;
    chk("rst.done", 32'(done), 0);
    chk("rst.next_x", 32'(next_pos_x), 0);
    chk("rst.next_y", 32'(next_pos_y), 0);
    chk("rst.next_angle", 32'(next_angle), 0);
    chk("rst.grid_x", 32'(grid_x), 0);
    chk("rst.trig_angle", 32'(trig_angle), 0);

    // First request after reset is applied.
    run_update("fwd", 14'h0880, 13'h0880, 8'h00, 0, 0, 1, 0, 10'sd511, 10'sd0,
               14'h089F, 13'h0880, 8'h00);
    idle(12);
    chk("hold.grid_x", 32'(grid_x), 8);
    chk("hold.grid_y", 32'(grid_y), 8);

    wall_en = 1;
    run_update("wall", 14'h08F0, 13'h0880, 8'h00, 0, 0, 1, 0, 10'sd511, 10'sd0,
               14'h08F0, 13'h0880, 8'h00);
    idle(12);
    run_update("slide", 14'h08F0, 13'h0880, 8'h00, 0, 0, 1, 0, 10'sd361, 10'sd361,
               14'h08F0, 13'h0896, 8'h00);
    wall_en = 0;
    idle(12);
    run_update("left_wrap", 14'h0880, 13'h0880, 8'h01, 0, 1, 0, 0, 10'sd511, 10'sd0,
               14'h0880, 13'h0880, 8'hFF);
    idle(4);
    chk("hold.trig_angle", 32'(trig_angle), 32'h0FF);
    idle(8);
    run_update("both_turn", 14'h0880, 13'h0880, 8'h40, 1, 1, 0, 0, 10'sd511, 10'sd0,
               14'h0880, 13'h0880, 8'h40);
    idle(12);
    run_update("fwd_bwd", 14'h0880, 13'h0880, 8'h00, 0, 0, 1, 1, 10'sd511, 10'sd0,
               14'h0880, 13'h0880, 8'h00);
    idle(12);
    run_update("bwd_neg", 14'h0880, 13'h0880, 8'h00, 0, 0, 0, 1, 10'sd511, -10'sd200,
               14'h0861, 13'h088D, 8'h00);
    idle(12);
    run_update("right_wrap", 14'h0880, 13'h0880, 8'hFF, 1, 0, 1, 0, 10'sd0, 10'sd511,
               14'h0880, 13'h089F, 8'h01);
    idle(12);
    run_update("x_over", 14'h3FF0, 13'h0880, 8'h00, 0, 0, 1, 0, 10'sd511, 10'sd0,
               14'h3FF0, 13'h0880, 8'h00);
    idle(12);
    run_update("x_under", 14'h0010, 13'h0880, 8'h00, 0, 0, 0, 1, 10'sd511, 10'sd0,
               14'h0010, 13'h0880, 8'h00);
    idle(12);
    run_update("y_over", 14'h0880, 13'h1FF0, 8'h00, 0, 0, 1, 0, 10'sd0, 10'sd511,
               14'h0880, 13'h1FF0, 8'h00);
    idle(12);

    // Throttle: starts at t0, t0+8 (pass-through) and t0+20 (applied).
    run_update("thr1", 14'h0880, 13'h0880, 8'h00, 0, 0, 1, 0, 10'sd511, 10'sd0,
               14'h089F, 13'h0880, 8'h00);
    run_update("thr2", 14'h0100, 13'h0100, 8'h10, 1, 0, 1, 0, 10'sd511, 10'sd0,
               14'h0100, 13'h0100, 8'h10);
    idle(4);
    run_update("thr3", 14'h0100, 13'h0100, 8'h10, 1, 0, 1, 0, 10'sd511, 10'sd0,
               14'h011F, 13'h0100, 8'h12);
    idle(12);

    // Reset three cycles after the accepted start aborts the update.
    cur_pos_x = 14'h0880; cur_pos_y = 13'h0880; cur_angle = 8'h00;
    move_forward = 1; lut_cos = 10'sd511; lut_sin = 10'sd0;
    start = 1;
    @(negedge clock);
    start = 0;
    idle(2);
    reset = 1;
    @(negedge clock);
    reset = 0;
    move_forward = 0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done) done_cnt++;
    end
    chk("abort.done_count", 32'(done_cnt), 0);
    chk("abort.next_x", 32'(next_pos_x), 0);
    chk("abort.next_y", 32'(next_pos_y), 0);
    chk("abort.next_angle", 32'(next_angle), 0);
    run_update("after_abort", 14'h0880, 13'h0880, 8'h00, 0, 0, 1, 0, 10'sd511, 10'sd0,
               14'h089F, 13'h0880, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
